// File: rtl/knn_run_ctrl.sv
// knn_run_ctrl: sequences test/training RAM reads into knn_top and scores its predictions.
// Optional WAIT-state watchdog with sticky timeout_o is enabled by defining KNN_RUN_WATCHDOG_EN.
module knn_run_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int FEATURES       = 8,
  parameter int MEM_WIDTH      = 72,
  parameter int TRAIN_AW       = 10,
  parameter int TEST_AW        = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [TRAIN_AW:0]              num_train_i,
  input  logic [TEST_AW:0]               num_test_i,
  output logic                           train_rd_en_o,
  output logic [TRAIN_AW-1:0]            train_rd_addr_o,
  input  logic [MEM_WIDTH-1:0]           train_rd_data_i,
  output logic                           test_rd_en_o,
  output logic [TEST_AW-1:0]             test_rd_addr_o,
  input  logic [MEM_WIDTH-1:0]           test_rd_data_i,
  output logic [DATA_WIDTH*FEATURES-1:0] knn_train_data_o,
  output logic                           knn_train_label_o,
  output logic                           knn_data_valid_o,
  output logic                           knn_training_done_o,
  output logic [DATA_WIDTH*FEATURES-1:0] knn_test_data_o,
  input  logic                           knn_pred_valid_i,
  input  logic                           knn_pred_label_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           result_valid_o,
  output logic                           result_label_o,
  output logic                           result_match_o,
  output logic [TEST_AW:0]               test_cnt_o,
  output logic [TEST_AW:0]               correct_cnt_o
`ifdef KNN_RUN_WATCHDOG_EN
  ,
  output logic                           timeout_o
`endif
);
  localparam int DW = DATA_WIDTH * FEATURES;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("knn_run_ctrl: GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end
  typedef enum logic [3:0] {IDLE, TLOAD, TLATCH, STREAM, FIN, WAIT, RECORD, GAP, DONE} state_t;
  state_t               r_state;
  logic [TRAIN_AW:0]    r_ntrain;
  logic [TEST_AW:0]     r_ntest;
  logic                 r_train_en;
  logic [TRAIN_AW-1:0]  r_train_addr;
  logic                 r_test_en;
  logic [TEST_AW-1:0]   r_test_addr;
  logic                 r_valid;
  logic                 r_td;
  logic [DW-1:0]        r_test_data;
  logic                 r_exp;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_res_valid;
  logic                 r_res_label;
  logic                 r_res_match;
  logic [TEST_AW:0]     r_test_cnt;
  logic [TEST_AW:0]     r_correct_cnt;
  logic [GW-1:0]        r_gap;
`ifdef KNN_RUN_WATCHDOG_EN
  logic [WW-1:0]        r_wd;
  logic                 r_timeout;
  assign timeout_o = r_timeout;
`endif
  logic [TRAIN_AW:0]    w_ntrain;
  logic [TEST_AW:0]     w_ntest;
  logic                 w_zero;
  logic                 w_last_train;
  logic                 w_last_test;
  logic                 w_match;
  logic                 w_unused;
  // counts above the RAM depth clamp to the full depth
  assign w_ntrain     = num_train_i[TRAIN_AW] ? {1'b1, {TRAIN_AW{1'b0}}} : num_train_i;
  assign w_ntest      = num_test_i[TEST_AW] ? {1'b1, {TEST_AW{1'b0}}} : num_test_i;
  assign w_zero       = (w_ntrain == '0) || (w_ntest == '0);
  assign w_last_train = {1'b0, r_train_addr} == r_ntrain - (TRAIN_AW+1)'(1);
  assign w_last_test  = {1'b0, r_test_addr} == r_ntest - (TEST_AW+1)'(1);
  assign w_match      = knn_pred_label_i == r_exp;
  assign w_unused     = ^{train_rd_data_i[MEM_WIDTH-DW-1:1], test_rd_data_i[MEM_WIDTH-DW-1:1]};
  assign knn_train_data_o    = train_rd_data_i[MEM_WIDTH-1 -: DW];
  assign knn_train_label_o   = train_rd_data_i[0];
  assign train_rd_en_o       = r_train_en;
  assign train_rd_addr_o     = r_train_addr;
  assign test_rd_en_o        = r_test_en;
  assign test_rd_addr_o      = r_test_addr;
  assign knn_data_valid_o    = r_valid;
  assign knn_training_done_o = r_td;
  assign knn_test_data_o     = r_test_data;
  assign busy_o              = r_busy;
  assign done_o              = r_done;
  assign result_valid_o      = r_res_valid;
  assign result_label_o      = r_res_label;
  assign result_match_o      = r_res_match;
  assign test_cnt_o          = r_test_cnt;
  assign correct_cnt_o       = r_correct_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ntrain      <= '0;
      r_ntest       <= '0;
      r_train_en    <= 1'b0;
      r_train_addr  <= '0;
      r_test_en     <= 1'b0;
      r_test_addr   <= '0;
      r_valid       <= 1'b0;
      r_td          <= 1'b0;
      r_test_data   <= '0;
      r_exp         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_label   <= 1'b0;
      r_res_match   <= 1'b0;
      r_test_cnt    <= '0;
      r_correct_cnt <= '0;
      r_gap         <= '0;
`ifdef KNN_RUN_WATCHDOG_EN
      r_wd          <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      // the training RAM has one cycle of read latency, so valid trails rd_en by one
      r_valid     <= r_train_en;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (start_i) begin
            r_ntrain      <= w_ntrain;
            r_ntest       <= w_ntest;
            r_test_cnt    <= '0;
            r_correct_cnt <= '0;
            r_test_addr   <= '0;
`ifdef KNN_RUN_WATCHDOG_EN
            r_timeout     <= 1'b0;
`endif
            if (w_zero) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= TLOAD;
              r_busy    <= 1'b1;
              r_test_en <= 1'b1;
            end
          end
        end
        TLOAD: begin
          r_test_en <= 1'b0;
          r_state   <= TLATCH;
        end
        TLATCH: begin
          r_test_data  <= test_rd_data_i[MEM_WIDTH-1 -: DW];
          r_exp        <= test_rd_data_i[0];
          r_train_en   <= 1'b1;
          r_train_addr <= '0;
          r_state      <= STREAM;
        end
        STREAM: begin
          if (w_last_train) begin
            r_train_en <= 1'b0;
            r_state    <= FIN;
          end else begin
            r_train_addr <= r_train_addr + TRAIN_AW'(1);
          end
        end
        FIN: begin
          r_td    <= 1'b1;
          r_state <= WAIT;
`ifdef KNN_RUN_WATCHDOG_EN
          r_wd    <= '0;
`endif
        end
        WAIT: begin
`ifdef KNN_RUN_WATCHDOG_EN
          r_wd <= r_wd + WW'(1);
`endif
          if (knn_pred_valid_i) begin
            r_td          <= 1'b0;
            r_res_valid   <= 1'b1;
            r_res_label   <= knn_pred_label_i;
            r_res_match   <= w_match;
            r_test_cnt    <= r_test_cnt + (TEST_AW+1)'(1);
            r_correct_cnt <= r_correct_cnt + (TEST_AW+1)'(w_match);
            r_state       <= RECORD;
          end
`ifdef KNN_RUN_WATCHDOG_EN
          else if (r_wd == WW'(TIMEOUT_CYCLES - 1)) begin
            r_td        <= 1'b0;
            r_res_valid <= 1'b1;
            r_res_label <= 1'b0;
            r_res_match <= 1'b0;
            r_test_cnt  <= r_test_cnt + (TEST_AW+1)'(1);
            r_timeout   <= 1'b1;
            r_state     <= RECORD;
          end
`endif
        end
        RECORD: begin
          r_gap   <= '0;
          r_state <= GAP;
        end
        GAP: begin
          if (r_gap == GW'(GAP_CYCLES - 1)) begin
            if (w_last_test) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_test_addr <= r_test_addr + TEST_AW'(1);
              r_test_en   <= 1'b1;
              r_state     <= TLOAD;
            end
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_knn_run_ctrl.sv
// tb_knn_run_ctrl: directed scoreboard bench for knn_run_ctrl with RAM models and a knn_top stub.
module tb_knn_run_ctrl;
  localparam int TAW = 10;
  localparam int EAW = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, start_i = 1'b0;
  logic [TAW:0] num_train_i = '0;
  logic [EAW:0] num_test_i = '0;
  logic train_rd_en_o, test_rd_en_o;
  logic [TAW-1:0] train_rd_addr_o;
  logic [EAW-1:0] test_rd_addr_o;
  logic [71:0] tr_q = '0, te_q = '0;
  logic [63:0] knn_train_data_o, knn_test_data_o;
  logic knn_train_label_o, knn_data_valid_o, knn_training_done_o;
  logic pv = 1'b0, spur = 1'b0, stub_label = 1'b1;
  int scnt = 0, stub_lat = 3;
  logic busy_o, done_o, result_valid_o, result_label_o, result_match_o;
  logic [EAW:0] test_cnt_o, correct_cnt_o;
`ifdef KNN_RUN_WATCHDOG_EN
  logic timeout_o;
`endif
  logic [71:0] test_mem [0:255];

  knn_run_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .num_train_i(num_train_i), .num_test_i(num_test_i),
    .train_rd_en_o(train_rd_en_o), .train_rd_addr_o(train_rd_addr_o), .train_rd_data_i(tr_q),
    .test_rd_en_o(test_rd_en_o), .test_rd_addr_o(test_rd_addr_o), .test_rd_data_i(te_q),
    .knn_train_data_o(knn_train_data_o), .knn_train_label_o(knn_train_label_o),
    .knn_data_valid_o(knn_data_valid_o), .knn_training_done_o(knn_training_done_o),
    .knn_test_data_o(knn_test_data_o),
    .knn_pred_valid_i(pv | spur), .knn_pred_label_i(stub_label),
    .busy_o(busy_o), .done_o(done_o), .result_valid_o(result_valid_o),
    .result_label_o(result_label_o), .result_match_o(result_match_o),
    .test_cnt_o(test_cnt_o), .correct_cnt_o(correct_cnt_o)
`ifdef KNN_RUN_WATCHDOG_EN
    , .timeout_o(timeout_o)
`endif
  );

  function automatic logic [71:0] trw(input logic [TAW-1:0] a);
    logic [63:0] f;
    f = ({54'd0, a} * 64'd2654435761) ^ 64'h0123_4567_89AB_CDEF;
    return {f, 7'd0, a[0] ^ a[2]};
  endfunction

  always @(posedge clk) if (train_rd_en_o) tr_q <= trw(train_rd_addr_o);
  always @(posedge clk) if (test_rd_en_o) te_q <= test_mem[test_rd_addr_o];
  // stub knn_top: answers stub_lat cycles after training_done rises
  always @(posedge clk) begin
    if (!knn_training_done_o) begin
      scnt <= 0;
      pv   <= 1'b0;
    end else begin
      scnt <= scnt + 1;
      pv   <= (scnt + 1 == stub_lat);
    end
  end

  typedef struct { logic m; logic l; logic [63:0] f; } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  int vcnt, vidx, trd, tst_rd, done_cnt, bad, td_bad, gap_min, since_res, tdc;
  logic in_gap, prev_v, prev_td;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    vcnt = 0; vidx = 0; trd = 0; tst_rd = 0; done_cnt = 0; bad = 0; td_bad = 0;
    gap_min = 999; since_res = 0; tdc = 0; in_gap = 1'b0; prev_v = 1'b0; prev_td = 1'b0;
  endtask

  task automatic cyc();
    exp_t e;
    logic [71:0] w;
    @(negedge clk);
    if (in_gap) since_res++;
    if (train_rd_en_o) trd++;
    if (test_rd_en_o) begin
      tst_rd++;
      vidx = 0;
      if (in_gap && since_res - 1 < gap_min) gap_min = since_res - 1;
      in_gap = 1'b0;
    end
    if (knn_data_valid_o) begin
      w = trw(vidx[TAW-1:0]);
      if (knn_train_data_o !== w[71:8] || knn_train_label_o !== w[0]) bad++;
      vidx++;
      vcnt++;
    end
    if (knn_training_done_o && (knn_data_valid_o || (!prev_td && !prev_v))) td_bad++;
    if (knn_training_done_o && (in_gap || result_valid_o)) td_bad++;
    if (knn_training_done_o) tdc++;
    if (done_o) begin
      done_cnt++;
      in_gap = 1'b0;
    end
    if (result_valid_o) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("res_match", result_match_o, e.m);
        chk("res_label", result_label_o, e.l);
        chk("res_tdata", knn_test_data_o, e.f);
      end
      in_gap = 1'b1;
      since_res = 0;
    end
    prev_v = knn_data_valid_o;
    prev_td = knn_training_done_o;
  endtask

  task automatic run(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) cyc();
    chk("run_done", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic go(input int ntr, input int nte);
    num_train_i = (TAW+1)'(ntr);
    num_test_i = (EAW+1)'(nte);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  function automatic int push_run(input int n, input logic lbl);
    int c = 0;
    for (int t = 0; t < n; t++) begin
      sb.push_back('{m: (lbl == test_mem[t][0]), l: lbl, f: test_mem[t][71:8]});
      c += (lbl == test_mem[t][0]) ? 1 : 0;
    end
    return c;
  endfunction

  initial begin
    int ec;
    for (int i = 0; i < 256; i++) test_mem[i] = {32'($urandom), 32'($urandom), 7'd0, 1'($urandom)};
    clr();
    repeat (3) cyc();
    chk("rst_ctl", {busy_o, done_o, train_rd_en_o, test_rd_en_o, knn_data_valid_o,
                    knn_training_done_o, result_valid_o}, 64'd0);
    chk("rst_cnt", {test_cnt_o, correct_cnt_o}, 64'd0);
    chk("rst_tdata", knn_test_data_o, 64'd0);
    rst = 1'b0;
    cyc();

    // single test, 614 training samples
    test_mem[0][0] = 1'b1;
    clr();
    ec = push_run(1, 1'b1);
    go(614, 1);
    chk("a_busy", busy_o, 64'd1);
    run(2000);
    chk("a_done_busy", busy_o, 64'd0);
    chk("a_valid_cnt", 64'(vcnt), 64'd614);
    chk("a_reads", 64'(trd), 64'd614);
    chk("a_order", 64'(bad), 64'd0);
    chk("a_td", 64'(td_bad), 64'd0);
    chk("a_cnt", {test_cnt_o, correct_cnt_o}, {9'd1, 9'd1});
    repeat (2) cyc();
    chk("a_done_once", 64'(done_cnt), 64'd1);

    // three tests, labels 1,0,1 against constant prediction 1
    test_mem[0][0] = 1'b1; test_mem[1][0] = 1'b0; test_mem[2][0] = 1'b1;
    clr();
    ec = push_run(3, 1'b1);
    go(20, 3);
    run(2000);
    chk("b_cnt", {test_cnt_o, correct_cnt_o}, {9'd3, 9'd2});
    chk("b_gap", 64'(gap_min), 64'd4);
    chk("b_valid_cnt", 64'(vcnt), 64'd60);
    chk("b_order", 64'(bad), 64'd0);
    chk("b_td", 64'(td_bad), 64'd0);

    // starts and a stray prediction outside WAIT are ignored
    test_mem[0][0] = 1'b1; test_mem[1][0] = 1'b1;
    clr();
    ec = push_run(2, 1'b1);
    go(30, 2);
    for (int i = 0; i < 200 && !(train_rd_en_o && train_rd_addr_o == 10'd5); i++) cyc();
    chk("c_reach_stream", train_rd_en_o, 64'd1);
    go(0, 0);
    spur = 1'b1; stub_label = 1'b0;
    cyc();
    spur = 1'b0; stub_label = 1'b1;
    for (int i = 0; i < 200 && !knn_training_done_o; i++) cyc();
    chk("c_reach_wait", knn_training_done_o, 64'd1);
    go(0, 0);
    run(2000);
    chk("c_cnt", {test_cnt_o, correct_cnt_o}, {9'd2, 9'(ec)});
    chk("c_done_cnt", 64'(done_cnt), 64'd1);
    chk("c_valid_cnt", 64'(vcnt), 64'd60);
    clr();
    void'(push_run(2, 1'b1));
    go(30, 2);
    chk("c_restart_clr", {busy_o, test_cnt_o, correct_cnt_o}, {1'b1, 18'd0});
    run(2000);
    chk("c_rerun_cnt", {test_cnt_o, correct_cnt_o}, {9'd2, 9'(ec)});

    // zero counts finish immediately with no RAM traffic
    clr();
    go(0, 2);
    chk("z_train0", {done_o, busy_o, test_cnt_o, correct_cnt_o}, {2'b10, 18'd0});
    go(5, 0);
    chk("z_test0", {done_o, busy_o, test_cnt_o, correct_cnt_o}, {2'b10, 18'd0});
    repeat (3) cyc();
    chk("z_reads", {16'(trd), 16'(tst_rd)}, 64'd0);
    chk("z_done_cnt", 64'(done_cnt), 64'd2);

    // test count saturates at 256
    clr();
    ec = push_run(256, 1'b1);
    go(1, 511);
    run(6000);
    chk("d_cnt", {test_cnt_o, correct_cnt_o}, {9'd256, 9'(ec)});
    chk("d_test_reads", 64'(tst_rd), 64'd256);
    chk("d_sb_empty", 64'(sb.size()), 64'd0);

    // training count saturates at 1024
    clr();
    ec = push_run(1, 1'b1);
    go(2047, 1);
    run(3000);
    chk("e_valid_cnt", 64'(vcnt), 64'd1024);
    chk("e_order", 64'(bad), 64'd0);

    // reset in the middle of streaming aborts the run
    clr();
    void'(push_run(2, 1'b1));
    go(300, 2);
    for (int i = 0; i < 500 && !(train_rd_en_o && train_rd_addr_o == 10'd200); i++) cyc();
    chk("r_reach", train_rd_addr_o, 64'd200);
    rst = 1'b1;
    cyc();
    chk("r_ctl", {busy_o, done_o, train_rd_en_o, test_rd_en_o, knn_data_valid_o,
                  knn_training_done_o, result_valid_o}, 64'd0);
    chk("r_addr", {train_rd_addr_o, test_rd_addr_o}, 64'd0);
    chk("r_tdata", knn_test_data_o, 64'd0);
    sb.delete();
    rst = 1'b0;
    repeat (5) cyc();
    chk("r_no_done", 64'(done_cnt), 64'd0);
    clr();
    ec = push_run(1, 1'b1);
    go(10, 1);
    run(500);
    chk("r_fresh_cnt", {test_cnt_o, correct_cnt_o}, {9'd1, 9'(ec)});

`ifdef KNN_RUN_WATCHDOG_EN
    // silent knn_top trips the watchdog
    clr();
    sb.push_back('{m: 1'b0, l: 1'b0, f: test_mem[0][71:8]});
    stub_lat = 1000000;
    go(5, 1);
    run(500);
    chk("w_timeout", timeout_o, 64'd1);
    chk("w_cnt", {test_cnt_o, correct_cnt_o}, {9'd1, 9'd0});
    chk("w_wait_cycles", 64'(tdc), 64'd16);
    stub_lat = 3;
    clr();
    ec = push_run(1, 1'b1);
    go(5, 1);
    chk("w_clear", timeout_o, 64'd0);
    run(500);
    chk("w_ok", {timeout_o, test_cnt_o, correct_cnt_o}, {1'b0, 9'd1, 9'(ec)});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/knn_run_ctrl.md
Name: knn_run_ctrl

Overview:
- Sequencer in front of knn_top: for each test vector it reads that test word from test RAM, streams every training word from training RAM into knn_top, then asserts training_done and collects the prediction.
- Scores each prediction against the label stored in the test word and keeps pass/total counters.
- Replaces the bench-driven streaming loop with hardware control, enabling full-dataset runs on silicon and FPGA.

Parameters:
- DATA_WIDTH, 8, feature width.
- FEATURES, 8, features per sample.
- MEM_WIDTH, 72, RAM word width. Layout: [71:8] = features, [0] = label, [7:1] unused.
- TRAIN_AW, 10, training RAM address width.
- TEST_AW, 8, test RAM address width.
- GAP_CYCLES, 4, idle cycles between tests (min 1).
- TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle run request.
- num_train_i  in  TRAIN_AW+1  training count, sampled on accepted start.
- num_test_i  in  TEST_AW+1  test count, sampled on accepted start.
- train_rd_en_o  out  1  training RAM read enable.
- train_rd_addr_o  out  TRAIN_AW  training RAM address.
- train_rd_data_i  in  MEM_WIDTH  training RAM data; valid 1 cycle after rd_en.
- test_rd_en_o  out  1  test RAM read enable.
- test_rd_addr_o  out  TEST_AW  test RAM address.
- test_rd_data_i  in  MEM_WIDTH  test RAM data; valid 1 cycle after rd_en.
- knn_train_data_o  out  DATA_WIDTH*FEATURES  equals train_rd_data_i[71:8] (combinational).
- knn_train_label_o  out  1  equals train_rd_data_i[0].
- knn_data_valid_o  out  1  training sample valid to knn_top.
- knn_training_done_o  out  1  finalize request to knn_top.
- knn_test_data_o  out  DATA_WIDTH*FEATURES  registered current test vector.
- knn_pred_valid_i  in  1  knn_top predicted_valid_o.
- knn_pred_label_i  in  1  knn_top predicted_label_o.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle run-complete pulse.
- result_valid_o  out  1  one-cycle pulse per scored test.
- result_label_o  out  1  predicted label, valid with result_valid_o.
- result_match_o  out  1  prediction equals expected label.
- test_cnt_o  out  TEST_AW+1  tests scored this run.
- correct_cnt_o  out  TEST_AW+1  matches this run.

Behaviour:
- Reset: every output register 0, state IDLE, counters 0, knn_test_data_o 0. Reset asserted mid-run aborts the run; no done_o pulse.
- Start acceptance: start_i is accepted only in IDLE or DONE and ignored otherwise. Acceptance clears both counters. busy_o rises the next cycle.
- Count handling: num_train_i above 2^TRAIN_AW saturates to 2^TRAIN_AW; num_test_i is handled the same way against 2^TEST_AW. If either count is 0, go straight to DONE with counters 0.
- FSM states:
  - IDLE: wait for start.
  - TLOAD: test_rd_en_o=1, addr=t.
  - TLATCH: latch test_rd_data_i[71:8] into knn_test_data_o and bit 0 into the expected label.
  - STREAM: train_rd_en_o=1 for num_train consecutive cycles, addresses 0..N-1 ascending.
  - FIN: knn_data_valid_o=0, knn_training_done_o=1.
  - WAIT: hold training_done until knn_pred_valid_i=1.
  - RECORD: result_valid_o=1, counters updated.
  - GAP: GAP_CYCLES cycles, training_done=0; then t+1 goes to TLOAD, or the last test goes to DONE.
  - DONE: done_o=1 for one cycle, busy_o=0, then IDLE. Counters hold until the next start.
- Stream timing: knn_data_valid_o is rd_en delayed by 1 cycle. knn_top therefore sees exactly num_train valid cycles with no bubbles, sample i at address i. knn_training_done_o asserts in the cycle after the last valid cycle.
- knn_test_data_o is stable from TLATCH through GAP.
- Prediction capture: knn_pred_valid_i is sampled only in WAIT and ignored in every other state. The result pulses in the cycle after pred_valid is seen, and training_done drops in that same cycle.
- Counting: test_cnt_o is incremented by 1 per RECORD. correct_cnt_o is incremented when result_match_o=1. Counter width cannot overflow because counts saturate at 2^TEST_AW.
- Latency per test = 2 + N + 1 + (pred latency) + 1 + GAP_CYCLES cycles.

Optional Feature:
- Macro: KNN_RUN_WATCHDOG_EN.
- Enabled: a counter runs in WAIT. If pred_valid is not seen within TIMEOUT_CYCLES, the controller:
  - emits result_valid_o with result_match_o=0 and result_label_o=0;
  - increments test_cnt_o only;
  - proceeds to GAP.
  - A sticky timeout_o (1-bit output port, present only when enabled) is set, and cleared on start or rst.
- Disabled: WAIT waits indefinitely; no timeout_o port exists.

Test Plan:
- num_train=614, num_test=1, stub knn returns label 1 after 3 cycles, test word label 1 -> exactly 614 knn_data_valid_o cycles at addresses 0..613, then result_match_o=1, correct_cnt_o=1, test_cnt_o=1, one done_o pulse.
- num_test=3, expected labels 1,0,1, stub predicts 1,1,1 -> result_match_o sequence 1,0,1; correct_cnt_o=2; at least 4 idle cycles with training_done=0 between tests.
- start_i pulsed during STREAM and WAIT -> ignored; run completes unchanged; a second start after done_o re-runs with counters cleared to 0.
- num_train=0 or num_test=0 -> done_o one cycle after acceptance, no RAM reads, counters 0.
- rst asserted mid-STREAM at address 200 -> next cycle all outputs 0, state IDLE, no done_o; a fresh start completes normally.
- With KNN_RUN_WATCHDOG_EN and TIMEOUT_CYCLES=16, stub never responds -> result after 16 WAIT cycles with match=0, timeout_o=1, test_cnt_o=1, correct_cnt_o=0.
